// File: rtl/dec_pkg.sv
// Shared types and helpers for the 4-to-16 pipelined one-hot decoder.
// Optional feature macro used by this block: DEC_PARITY_EN (see top module).
package dec_pkg;

    localparam int DEC_IN_W    = 4;
    localparam int DEC_OUT_W   = 2 ** DEC_IN_W;
    localparam int DEC_ENTRY_W = DEC_OUT_W + DEC_IN_W;

    // Buffer occupancy of the 2-entry output skid FIFO
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

    typedef struct packed {
        logic [DEC_OUT_W-1:0] onehot;
        logic [DEC_IN_W-1:0]  code;
    } dec_entry_t;

    // One-hot word for a code; all zeros when the decoder is disabled
    function automatic logic [DEC_OUT_W-1:0] onehot_of(input logic [DEC_IN_W-1:0] code,
                                                       input logic                en);
        logic [DEC_OUT_W-1:0] word;
        word = '0;
        if (en) begin
            word[code] = 1'b1;
        end
        return word;
    endfunction

endpackage

// File: rtl/dec_skid_fifo.sv
// Two-entry FIFO of decoder entries. Slot 0 is always the head, so the
// output is taken straight from a register. Empty slots are held at zero so
// the head reads as zero when the buffer is empty.
//
// state     | meaning
// OCC_EMPTY | no entries buffered
// OCC_ONE   | head valid, tail slot free
// OCC_TWO   | both slots valid, push not allowed
module dec_skid_fifo
    import dec_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   push,
    input  logic                   pop,
    input  logic [DEC_ENTRY_W-1:0] din,
    output logic [DEC_ENTRY_W-1:0] dout,
    output logic                   full,
    output logic                   empty
);

    occ_state_t state;
    dec_entry_t slot0;
    dec_entry_t slot1;
    logic       full_q;
    logic       empty_q;

    // Occupancy FSM with slot moves and registered full/empty flags
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= OCC_EMPTY;
            slot0   <= '0;
            slot1   <= '0;
            full_q  <= 1'b0;
            empty_q <= 1'b1;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (push) begin
                        slot0   <= dec_entry_t'(din);
                        state   <= OCC_ONE;
                        empty_q <= 1'b0;
                    end
                end
                OCC_ONE: begin
                    if (push && pop) begin
                        // Head leaves and the new entry takes its place
                        slot0 <= dec_entry_t'(din);
                    end else if (push) begin
                        slot1  <= dec_entry_t'(din);
                        state  <= OCC_TWO;
                        full_q <= 1'b1;
                    end else if (pop) begin
                        slot0   <= '0;
                        state   <= OCC_EMPTY;
                        empty_q <= 1'b1;
                    end
                end
                OCC_TWO: begin
                    // Push is blocked upstream while full; only a pop moves us
                    if (pop) begin
                        slot0  <= slot1;
                        slot1  <= '0;
                        state  <= OCC_ONE;
                        full_q <= 1'b0;
                    end
                end
                default: begin
                    state   <= OCC_EMPTY;
                    slot0   <= '0;
                    slot1   <= '0;
                    full_q  <= 1'b0;
                    empty_q <= 1'b1;
                end
            endcase
        end
    end

    // Head and status flags come straight from registers
    always_comb begin
        dout  = slot0;
        full  = full_q;
        empty = empty_q;
    end

endmodule

// File: rtl/decoder_4_by_16_pipe.sv
// Registered 4-to-16 one-hot decoder with valid/ready on both sides.
// Codes are decoded on accept and stored in a 2-entry skid FIFO so
// downstream backpressure never drops a code. dec_count counts delivered
// words whose one-hot is non-zero and saturates at its maximum.
// Optional macro DEC_PARITY_EN adds in_parity/par_err: an entry failing
// even parity is delivered with a zero one-hot and is not counted.
// IN_W must match dec_pkg::DEC_IN_W since the buffered entry type is fixed.
module decoder_4_by_16_pipe
    import dec_pkg::*;
#(
    parameter int IN_W  = DEC_IN_W,
    parameter int CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [IN_W-1:0]      in_code,
    input  logic                 in_en,
`ifdef DEC_PARITY_EN
    input  logic                 in_parity,
    output logic                 par_err,
`endif
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2**IN_W-1:0]   out_onehot,
    output logic [IN_W-1:0]      out_code,
    output logic [CNT_W-1:0]     dec_count
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    logic                   fifo_full;
    logic                   fifo_empty;
    logic                   push;
    logic                   pop;
    logic                   dec_en;
    dec_entry_t             new_entry;
    dec_entry_t             head_entry;
    logic [DEC_ENTRY_W-1:0] head_bits;
    logic [CNT_W-1:0]       count_q;

`ifdef DEC_PARITY_EN
    logic par_bad;
    logic par_err_q;

    // Even parity over code plus parity bit; a set reduction means a fault
    always_comb begin
        par_bad = ^{in_code, in_parity};
        dec_en  = in_en && !par_bad;
    end

    // One-cycle error pulse after an accepting edge with bad parity
    always_ff @(posedge clk) begin
        if (rst) begin
            par_err_q <= 1'b0;
        end else begin
            par_err_q <= push && par_bad;
        end
    end

    assign par_err = par_err_q;
`else
    // Without parity checking the enable passes straight through
    always_comb begin
        dec_en = in_en;
    end
`endif

    // Handshake glue and decode ahead of storage
    always_comb begin
        in_ready         = !rst && !fifo_full;
        out_valid        = !fifo_empty;
        push             = in_valid && in_ready;
        pop              = out_valid && out_ready && !rst;
        new_entry.onehot = onehot_of(in_code, dec_en);
        new_entry.code   = in_code;
        head_entry       = dec_entry_t'(head_bits);
        out_onehot       = head_entry.onehot;
        out_code         = head_entry.code;
    end

    dec_skid_fifo u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (pop),
        .din   (new_entry),
        .dout  (head_bits),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    // Count delivered words with a non-zero one-hot, saturating at max
    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= '0;
        end else if (pop && (head_entry.onehot != '0) && (count_q != CNT_MAX)) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign dec_count = count_q;

endmodule

// File: tb/tb_decoder_4_by_16_pipe.sv
// Directed bench for decoder_4_by_16_pipe with hand-computed expectations.
// A second instance with a 3-bit counter shares the stimulus to exercise
// saturation. Parity checks are compiled in only with DEC_PARITY_EN.
module tb_decoder_4_by_16_pipe;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic [3:0]  in_code;
    logic        in_en;
    logic        out_ready;
    logic        in_ready;
    logic        out_valid;
    logic [15:0] out_onehot;
    logic [3:0]  out_code;
    logic [15:0] dec_count;

    logic        s_in_ready;
    logic        s_out_valid;
    logic [15:0] s_out_onehot;
    logic [3:0]  s_out_code;
    logic [2:0]  s_dec_count;

`ifdef DEC_PARITY_EN
    logic        in_parity;
    logic        par_err;
    logic        s_par_err;
`endif

    int n_vec;
    int n_bad;

    decoder_4_by_16_pipe #(.IN_W(4), .CNT_W(16)) u_dut (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
`ifdef DEC_PARITY_EN
        .in_parity  (in_parity),
        .par_err    (par_err),
`endif
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_onehot (out_onehot),
        .out_code   (out_code),
        .dec_count  (dec_count)
    );

    decoder_4_by_16_pipe #(.IN_W(4), .CNT_W(3)) u_sat (
        .clk        (clk),
        .rst        (rst),
        .in_valid   (in_valid),
        .in_ready   (s_in_ready),
        .in_code    (in_code),
        .in_en      (in_en),
`ifdef DEC_PARITY_EN
        .in_parity  (in_parity),
        .par_err    (s_par_err),
`endif
        .out_valid  (s_out_valid),
        .out_ready  (out_ready),
        .out_onehot (s_out_onehot),
        .out_code   (s_out_code),
        .dec_count  (s_dec_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Advance one active edge and land on the following falling edge
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        n_vec     = 0;
        n_bad     = 0;
        rst       = 1'b1;
        in_valid  = 1'b1;
        in_code   = 4'h5;
        in_en     = 1'b1;
        out_ready = 1'b0;
`ifdef DEC_PARITY_EN
        in_parity = 1'b0;
`endif
        @(negedge clk);

        // Reset held two cycles with in_valid high
        step();
        step();
        chk("rst_in_ready",   32'(in_ready),   32'h0);
        chk("rst_out_valid",  32'(out_valid),  32'h0);
        chk("rst_onehot",     32'(out_onehot), 32'h0);
        chk("rst_out_code",   32'(out_code),   32'h0);
        chk("rst_count",      32'(dec_count),  32'h0);
        in_valid = 1'b0;
        rst      = 1'b0;
        #1;
        chk("rel_in_ready",   32'(in_ready),   32'h1);

        // Back-to-back sweep of all codes with the consumer always ready
        out_ready = 1'b1;
        in_en     = 1'b1;
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_code  = 4'(i);
            #1;
            chk("sweep_in_ready", 32'(in_ready), 32'h1);
            step();
            chk("sweep_valid",    32'(out_valid),   32'h1);
            chk("sweep_onehot",   32'(out_onehot),  32'h1 << i);
            chk("sweep_code",     32'(out_code),    32'(i));
            chk("sweep_count",    32'(dec_count),   32'(i));
            chk("sat_count",      32'(s_dec_count), 32'((i < 7) ? i : 7));
        end
        in_valid = 1'b0;
        step();
        chk("sweep_drained",  32'(out_valid),   32'h0);
        chk("sweep_total",    32'(dec_count),   32'd16);
        chk("sat_final",      32'(s_dec_count), 32'd7);

        // Decoder disabled: zero word delivered, code echoed, not counted
        in_valid = 1'b1;
        in_en    = 1'b0;
        in_code  = 4'h7;
        step();
        in_valid = 1'b0;
        chk("dis_valid",  32'(out_valid),  32'h1);
        chk("dis_onehot", 32'(out_onehot), 32'h0);
        chk("dis_code",   32'(out_code),   32'h7);
        step();
        chk("dis_drained", 32'(out_valid), 32'h0);
        chk("dis_count",   32'(dec_count), 32'd16);

        // Backpressure: 3 and 5 fill the buffer, 9 waits
        in_en     = 1'b1;
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 4'h3;
        step();
        in_code = 4'h5;
        chk("bp_ready_one", 32'(in_ready), 32'h1);
        step();
        in_code = 4'h9;
        chk("bp_ready_full", 32'(in_ready),   32'h0);
        chk("bp_head_a",     32'(out_onehot), 32'h0008);
        step();
        chk("bp_still_full", 32'(in_ready),   32'h0);
        chk("bp_head_b",     32'(out_onehot), 32'h0008);
        chk("bp_head_code",  32'(out_code),   32'h3);
        step();
        chk("bp_head_c",     32'(out_onehot), 32'h0008);
        out_ready = 1'b1;
        step();
        chk("bp_second",     32'(out_onehot), 32'h0020);
        chk("bp_ready_back", 32'(in_ready),   32'h1);
        step();
        in_valid = 1'b0;
        chk("bp_third",      32'(out_onehot), 32'h0200);
        chk("bp_third_code", 32'(out_code),   32'h9);
        step();
        chk("bp_drained",    32'(out_valid),  32'h0);
        chk("bp_count",      32'(dec_count),  32'd19);

`ifdef DEC_PARITY_EN
        // Bad parity zeroes the word and pulses par_err; good parity decodes
        in_valid  = 1'b1;
        in_code   = 4'h1;
        in_parity = 1'b0;
        step();
        in_parity = 1'b1;
        chk("par_err_pulse", 32'(par_err),    32'h1);
        chk("par_bad_word",  32'(out_onehot), 32'h0);
        chk("par_bad_code",  32'(out_code),   32'h1);
        step();
        in_valid = 1'b0;
        chk("par_err_clear", 32'(par_err),    32'h0);
        chk("par_good_word", 32'(out_onehot), 32'h0002);
        step();
        chk("par_count",     32'(dec_count),  32'd20);
`endif

        // Reset mid-operation discards buffered entries
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_code   = 4'h6;
        step();
        step();
        in_valid = 1'b0;
        chk("mid_full",      32'(in_ready),  32'h0);
        rst       = 1'b1;
        out_ready = 1'b1;
        step();
        chk("mid_valid",     32'(out_valid),  32'h0);
        chk("mid_onehot",    32'(out_onehot), 32'h0);
        chk("mid_count",     32'(dec_count),  32'h0);
        chk("mid_in_ready",  32'(in_ready),   32'h0);
        rst = 1'b0;
        #1;
        chk("mid_release",   32'(in_ready),   32'h1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
